multi_puff_timer: RTL
=====================

Name: multi_puff_timer

Overview:
Multi-channel successor to the single-bank fuel injection timer. It counts debounced ignition-coil rising edges and fires one injector puff every IGN_PER_PUFF edges. Triggers are assigned round-robin across CHANNELS injector outputs, which gives sequential injection, and each channel has its own µs puff-length countdown. It sits between the ignition input pin, the MCU (which supplies lengths and enable) and the injector solenoid drivers.

Parameters:
CHANNELS, 4, number of injector outputs sequenced round-robin (1..8).
IGN_PER_PUFF, 4, debounced ignition rising edges per puff trigger (1..255).
LEN_WIDTH, 16, width of puff_len_us and ign_timeout_len_jf and their countdowns.
DEBOUNCE_WIDTH, 4, debounce counter width; the input must be stable for 2^DEBOUNCE_WIDTH-1 pulse1m ticks.

Ports:
sysclk  in  1  system clock; single clock domain.
sysreset  in  1  synchronous, active-high reset.
pulse50k  in  1  1-sysclk strobe at 50 kHz; timeout tick (20 µs "jf").
pulse1m  in  1  1-sysclk strobe at 1 MHz; puff-length and debounce tick.
ign_coil  in  1  asynchronous ignition coil sense.
ign_timeout_len_jf  in  LEN_WIDTH  timeout in pulse50k ticks; 0 disables the timeout.
puff_len_us  in  LEN_WIDTH  puff length in pulse1m ticks; sampled at trigger.
puff_enable  in  1  high = run; low = hold everything idle and reinitialised.
puff_on_timeout  in  1  high = timeout expiry also triggers a puff.
injector_open  out  CHANNELS  per-channel solenoid drive, registered.
puff_event  out  1  OR of injector_open; MCU coordination.
puff_channel  out  max(1,$clog2(CHANNELS))  channel of the most recent trigger.
puff_overrun  out  1  1-cycle pulse when a trigger lands on a channel that is still open.

Behaviour:
- Reset (sysreset=1 on a sysclk edge): injector_open=0, puff_event=0, puff_channel=0, puff_overrun=0. Edge counter loads IGN_PER_PUFF, timeout loads ign_timeout_len_jf, channel pointer=0, debounce state=0. Reset overrides all other inputs.
- Input path: 2-flop synchroniser, then debounce counter clocked by pulse1m. The debounced level flips only after 2^DEBOUNCE_WIDTH-1 consecutive agreeing ticks. ign_rise is a 1-cycle pulse on a debounced 0->1 transition.
- Edge counter: decrements on ign_rise. When it reaches 0, edge_trig fires and the counter reloads IGN_PER_PUFF in the same cycle.
- Timeout counter: decrements on pulse50k and holds at 0. to_trig fires for exactly one cycle on the first cycle at 0, and only if puff_on_timeout=1 and ign_timeout_len_jf!=0. It reloads on every trigger (edge or timeout).
- trigger = (edge_trig | to_trig) & puff_enable. If both fire in the same cycle, only one trigger is produced.
- On trigger at cycle N:
  - Channel c = pointer loads countdown[c] = puff_len_us.
  - puff_channel = c at N+1.
  - Pointer advances, wrapping CHANNELS-1 -> 0.
  - injector_open[c]=1 at N+1 if puff_len_us != 0.
- Countdown[c] decrements on each pulse1m. injector_open[c] clears on the cycle after the countdown reaches 0. Open time is puff_len_us µs, ±1 pulse1m period.
- puff_len_us=0: nothing opens, but the pointer still advances and puff_channel still updates.
- Trigger on a channel whose countdown is nonzero: the countdown reloads, the output stays high, and puff_overrun pulses at N+1.
- Channels run independently; several may be open at once.
- puff_enable=0: every cycle reloads the edge counter and timeout counter, zeroes all countdowns, sets the pointer to 0 and clears injector_open on the next cycle. The debouncer keeps running.
- On the cycle puff_enable rises, the counters reload with current input values. Because ign_timeout_len_jf=0 disables the timeout, no latch-up is possible.
- Length and timeout inputs may change at any time; they take effect only at the next load.

Optional Feature:
PUFF_PEAK_HOLD_EN.
- Defined: adds input hold_delay_us (LEN_WIDTH) and parameter HOLD_DUTY_SHIFT (default 2). While a channel is open, injector_open[c] is solid for the first hold_delay_us µs (peak). After that it PWMs: high for 1 of every 2^HOLD_DUTY_SHIFT pulse1m ticks, phase-aligned to the peak end. puff_event still reports the logical open interval.
- Not defined: injector_open equals the logical open interval, the port is absent and behaviour is exactly as above.

Test Plan:
1. Reset: sysreset=1 with ign_coil toggling -> all outputs 0. After release, 4 debounced rises -> injector_open=4'b0001, puff_channel=0.
2. puff_len_us=1000, 16 debounced rises at 10 kHz -> channels 0,1,2,3 each open 1000±1 µs in order, and the pointer wraps to 0.
3. Glitch test: a 10 µs ign_coil pulse is rejected; a 20 µs pulse is counted once.
4. Timeout: ign idle, ign_timeout_len_jf=500, puff_on_timeout=1 -> a puff every 10 ms ±20 µs. With puff_on_timeout=0, or ign_timeout_len_jf=0 -> no puff.
5. Overrun: CHANNELS=1, puff_len_us=5000, triggers 2 ms apart -> puff_overrun pulses and the output stays high until 5 ms after the last trigger.
6. Drop puff_enable mid-puff -> injector_open=0 next cycle. Re-raise -> the next puff lands on channel 0 after 4 fresh rises. Also test sysreset asserted mid-puff.

Source files
------------

// File: rtl/multi_puff_timer.sv
// rtl/multi_puff_timer.sv - round-robin multi-channel injector puff timer
//
// Counts debounced ignition-coil rising edges and fires one injector puff
// every IGN_PER_PUFF edges (or on an idle-ignition timeout). Triggers are
// dealt round-robin across CHANNELS outputs, each with its own 1 us countdown.
//
// Optional build macro: PUFF_PEAK_HOLD_EN (peak-and-hold PWM drive,
// adds hold_delay_us input and HOLD_DUTY_SHIFT parameter).
//
// Ports:
//   sysclk, sysreset      clock, synchronous active-high reset
//   pulse50k, pulse1m     1-cycle tick strobes (20 us timeout tick, 1 us tick)
//   ign_coil              asynchronous ignition coil sense
//   ign_timeout_len_jf    timeout in pulse50k ticks, 0 disables
//   puff_len_us           puff length in pulse1m ticks, sampled at trigger
//   puff_enable           run / hold idle and reinitialised
//   puff_on_timeout       timeout expiry also triggers a puff
//   hold_delay_us         (PUFF_PEAK_HOLD_EN only) solid peak time
//   injector_open         per-channel solenoid drive
//   puff_event            OR of logical open intervals
//   puff_channel          channel of the most recent trigger
//   puff_overrun          1-cycle pulse on trigger to a still-open channel

module multi_puff_timer #(
    parameter int CHANNELS       = 4,
    parameter int IGN_PER_PUFF   = 4,
    parameter int LEN_WIDTH      = 16,
    parameter int DEBOUNCE_WIDTH = 4
`ifdef PUFF_PEAK_HOLD_EN
    ,
    parameter int HOLD_DUTY_SHIFT = 2
`endif
) (
    input  logic                 sysclk,
    input  logic                 sysreset,
    input  logic                 pulse50k,
    input  logic                 pulse1m,
    input  logic                 ign_coil,
    input  logic [LEN_WIDTH-1:0] ign_timeout_len_jf,
    input  logic [LEN_WIDTH-1:0] puff_len_us,
    input  logic                 puff_enable,
    input  logic                 puff_on_timeout,
`ifdef PUFF_PEAK_HOLD_EN
    input  logic [LEN_WIDTH-1:0] hold_delay_us,
`endif
    output logic [CHANNELS-1:0]  injector_open,
    output logic                 puff_event,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] puff_channel,
    output logic                 puff_overrun
);

    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [7:0] EDGE_RELOAD = 8'(IGN_PER_PUFF);
    // Flip happens on the (2^W-1)th consecutive disagreeing tick.
    localparam logic [DEBOUNCE_WIDTH-1:0] DEB_FLIP = DEBOUNCE_WIDTH'((2 ** DEBOUNCE_WIDTH) - 2);

    // ---------------- input path ----------------
    logic                      ign_meta;
    logic                      ign_sync;
    logic                      deb_level;
    logic                      deb_prev;
    logic [DEBOUNCE_WIDTH-1:0] deb_cnt;
    logic                      ign_rise;

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            ign_meta  <= 1'b0;
            ign_sync  <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            ign_meta <= ign_coil;
            ign_sync <= ign_meta;
            deb_prev <= deb_level;
            if (pulse1m) begin
                if (ign_sync == deb_level) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_FLIP) begin
                    deb_cnt   <= '0;
                    deb_level <= ign_sync;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end
    end

    assign ign_rise = deb_level & ~deb_prev;

    // ---------------- trigger sources ----------------
    logic [7:0]           edge_cnt;
    logic [LEN_WIDTH-1:0] to_cnt;
    logic                 to_done;   // first cycle at zero already seen
    logic                 edge_trig;
    logic                 to_trig;
    logic                 trigger;

    assign edge_trig = ign_rise && (edge_cnt == 8'd1);
    assign to_trig   = (to_cnt == '0) && !to_done && puff_on_timeout &&
                       (ign_timeout_len_jf != '0);
    assign trigger   = (edge_trig | to_trig) & puff_enable;

    always_ff @(posedge sysclk) begin
        if (sysreset || !puff_enable) begin
            edge_cnt <= EDGE_RELOAD;
            to_cnt   <= ign_timeout_len_jf;
            to_done  <= 1'b0;
        end else begin
            if (edge_trig) begin
                edge_cnt <= EDGE_RELOAD;
            end else if (ign_rise) begin
                edge_cnt <= edge_cnt - 1'b1;
            end

            if (trigger) begin
                to_cnt  <= ign_timeout_len_jf;
                to_done <= 1'b0;
            end else if (to_cnt == '0) begin
                to_done <= 1'b1;
            end else if (pulse50k) begin
                to_cnt <= to_cnt - 1'b1;
            end
        end
    end

    // ---------------- channels ----------------
    logic [LEN_WIDTH-1:0] countdown [CHANNELS];
    logic [LEN_WIDTH-1:0] cd_next   [CHANNELS];
    logic [CHANNELS-1:0]  open_q;
    logic [CHANNELS-1:0]  open_next;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [PTR_W-1:0]     ch_next;
    logic                 ovr_next;

    always_comb begin
        cd_next   = countdown;
        open_next = open_q;
        ptr_next  = ptr;
        ch_next   = puff_channel;
        ovr_next  = 1'b0;

        for (int c = 0; c < CHANNELS; c++) begin
            // Output samples the pre-decrement count, so it drops one
            // cycle after the countdown lands on zero.
            open_next[c] = (countdown[c] != '0);
            if (pulse1m && (countdown[c] != '0)) begin
                cd_next[c] = countdown[c] - 1'b1;
            end
            if (trigger && (ptr == PTR_W'(c))) begin
                cd_next[c]   = puff_len_us;
                open_next[c] = (puff_len_us != '0);
                ovr_next     = (countdown[c] != '0);
            end
        end

        if (trigger) begin
            ch_next  = ptr;
            ptr_next = (ptr == PTR_W'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
        end

        if (!puff_enable) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cd_next[c] = '0;
            end
            open_next = '0;
            ptr_next  = '0;
            ovr_next  = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                countdown[c] <= '0;
            end
            open_q       <= '0;
            ptr          <= '0;
            puff_channel <= '0;
            puff_overrun <= 1'b0;
        end else begin
            countdown    <= cd_next;
            open_q       <= open_next;
            ptr          <= ptr_next;
            puff_channel <= ch_next;
            puff_overrun <= ovr_next;
        end
    end

    assign puff_event = |open_q;

`ifdef PUFF_PEAK_HOLD_EN
    // ---------------- peak-and-hold drive ----------------
    localparam int PW = (HOLD_DUTY_SHIFT > 0) ? HOLD_DUTY_SHIFT : 1;

    logic [LEN_WIDTH-1:0] peak_cnt  [CHANNELS];
    logic [LEN_WIDTH-1:0] peak_next [CHANNELS];
    logic [PW-1:0]        pwm_cnt   [CHANNELS];
    logic [PW-1:0]        pwm_next  [CHANNELS];
    logic [CHANNELS-1:0]  drive_q;
    logic [CHANNELS-1:0]  drive_next;

    always_comb begin
        peak_next  = peak_cnt;
        pwm_next   = pwm_cnt;
        drive_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (pulse1m && (peak_cnt[c] != '0)) begin
                peak_next[c] = peak_cnt[c] - 1'b1;
            end
            if (trigger && (ptr == PTR_W'(c))) begin
                peak_next[c] = hold_delay_us;
            end
            // Phase counter sits at zero during the peak, so the first
            // hold tick after the peak is a high one.
            if (peak_cnt[c] != '0) begin
                pwm_next[c] = '0;
            end else if (pulse1m) begin
                pwm_next[c] = (HOLD_DUTY_SHIFT == 0) ? '0 : pwm_cnt[c] + 1'b1;
            end
            if (!puff_enable) begin
                peak_next[c] = '0;
                pwm_next[c]  = '0;
            end
            drive_next[c] = open_next[c] &
                            ((peak_next[c] != '0) || (pwm_next[c] == '0));
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                peak_cnt[c] <= '0;
                pwm_cnt[c]  <= '0;
            end
            drive_q <= '0;
        end else begin
            peak_cnt <= peak_next;
            pwm_cnt  <= pwm_next;
            drive_q  <= drive_next;
        end
    end

    assign injector_open = drive_q;
`else
    assign injector_open = open_q;
`endif

endmodule
